// File: rtl/lagarto_rst_seq_pkg.sv
// Shared types and helpers for the Lagarto tile reset sequencer.
//   rst_seq_state_e : sequencer FSM states
//   SOFT_CNT_W      : width of each per-hart soft-reset counter
//   cnt_w()         : bits needed to hold a count 0..cycles
package lagarto_rst_seq_pkg;

  typedef enum logic [1:0] {
    WAKE    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    HOLD    = 2'd3
  } rst_seq_state_e;

  localparam int SOFT_CNT_W = 8;

  function automatic int cnt_w(input int cycles);
    int w;
    w = 1;
    while ((1 << w) < cycles + 1) w++;
    return w;
  endfunction

endpackage

// File: rtl/lagarto_rst_sync.sv
// Reset synchronizer: asynchronous assertion, synchronous deassertion.
//   clk_i : destination clock
//   rst_i : raw reset, active-high
//   rst_o : synchronized reset, active-high, deasserts STAGES edges after rst_i drops
module lagarto_rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic rst_o
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_sync <= '0;
    else       r_sync <= {r_sync[STAGES-2:0], 1'b1};
  end

  assign rst_o = ~r_sync[STAGES-1];

endmodule

// File: rtl/lagarto_tile_rst_seq.sv
// Multi-hart reset / wake-up sequencer for the Lagarto tile.
// After reset, waits WAKE_CYCLES, releases harts one by one STAGGER_CYCLES
// apart, then serves per-hart soft-reset requests (lowest index first),
// holding the selected hart in reset for HOLD_CYCLES and pulsing its ack.
// Ports:
//   clk_i, rst_i       : tile clock, async active-high reset
//   soft_rst_req_i     : per-hart soft-reset request (level)
//   soft_rst_ack_o     : per-hart one-cycle completion pulse
//   hart_rst_no        : per-hart active-low core reset
//   all_up_o, busy_o   : all harts running / sequencer not idle in RUN
//   soft_rst_cnt_o     : per-hart 8-bit saturating soft-reset counters
// Optional: LAGARTO_RST_SEQ_CNT_EN builds the counters; otherwise tied to 0.
module lagarto_tile_rst_seq
  import lagarto_rst_seq_pkg::*;
#(
  parameter int NUM_HARTS      = 4,
  parameter int WAKE_CYCLES    = 32768,
  parameter int STAGGER_CYCLES = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_HARTS-1:0]            soft_rst_req_i,
  output logic [NUM_HARTS-1:0]            soft_rst_ack_o,
  output logic [NUM_HARTS-1:0]            hart_rst_no,
  output logic                            all_up_o,
  output logic                            busy_o,
  output logic [NUM_HARTS*SOFT_CNT_W-1:0] soft_rst_cnt_o
);

  if (NUM_HARTS < 1 || NUM_HARTS > 16) begin : g_chk_harts
    $error("NUM_HARTS must be in 1..16");
  end
  if (WAKE_CYCLES < 1) begin : g_chk_wake
    $error("WAKE_CYCLES must be >= 1");
  end
  if (STAGGER_CYCLES < 1) begin : g_chk_stagger
    $error("STAGGER_CYCLES must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_chk_hold
    $error("HOLD_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be >= 2");
  end

  localparam int WK_W  = cnt_w(WAKE_CYCLES);
  localparam int ST_W  = cnt_w(STAGGER_CYCLES);
  localparam int HD_W  = cnt_w(HOLD_CYCLES);
  localparam int IDX_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

  logic w_srst;

  lagarto_rst_sync #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rst_o (w_srst)
  );

  rst_seq_state_e       r_state, w_state_nxt;
  logic [WK_W-1:0]      r_wcnt, w_wcnt_nxt;
  logic [ST_W-1:0]      r_scnt, w_scnt_nxt;
  logic [HD_W-1:0]      r_hcnt, w_hcnt_nxt;
  // Release index during RELEASE, hart under soft reset during HOLD.
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [NUM_HARTS-1:0] r_hart_rstn, w_hart_rstn_nxt;
  logic [NUM_HARTS-1:0] r_ack, w_ack_nxt;
  logic [NUM_HARTS-1:0] r_armed, w_armed_nxt;
  logic                 r_all_up, w_all_up_nxt;
  logic                 r_busy, w_busy_nxt;

  logic [NUM_HARTS-1:0] w_pend;
  logic [IDX_W-1:0]     w_sel;
  logic [IDX_W-1:0]     w_idx_inc;
  logic                 w_any;

  // Lowest-index armed request wins.
  always_comb begin
    w_pend = soft_rst_req_i & r_armed;
    w_sel  = '0;
    for (int i = NUM_HARTS - 1; i >= 0; i--)
      if (w_pend[i]) w_sel = IDX_W'(i);
  end

  assign w_any     = |w_pend;
  assign w_idx_inc = r_idx + IDX_W'(1);

  always_ff @(posedge clk_i or posedge w_srst) begin
    if (w_srst) begin
      r_state     <= WAKE;
      r_wcnt      <= '0;
      r_scnt      <= '0;
      r_hcnt      <= '0;
      r_idx       <= '0;
      r_hart_rstn <= '0;
      r_ack       <= '0;
      // A request already high when RUN is reached must still be served.
      r_armed     <= '1;
      r_all_up    <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_wcnt      <= w_wcnt_nxt;
      r_scnt      <= w_scnt_nxt;
      r_hcnt      <= w_hcnt_nxt;
      r_idx       <= w_idx_nxt;
      r_hart_rstn <= w_hart_rstn_nxt;
      r_ack       <= w_ack_nxt;
      r_armed     <= w_armed_nxt;
      r_all_up    <= w_all_up_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_wcnt_nxt      = r_wcnt;
    w_scnt_nxt      = r_scnt;
    w_hcnt_nxt      = r_hcnt;
    w_idx_nxt       = r_idx;
    w_hart_rstn_nxt = r_hart_rstn;
    w_ack_nxt       = '0;
    // Re-arm once the request is seen low, in any state.
    w_armed_nxt     = r_armed | ~soft_rst_req_i;
    w_all_up_nxt    = r_all_up;
    w_busy_nxt      = r_busy;
    case (r_state)
      WAKE: begin
        if (r_wcnt == WK_W'(WAKE_CYCLES)) begin
          w_hart_rstn_nxt[0] = 1'b1;
          w_idx_nxt          = '0;
          w_scnt_nxt         = '0;
          if (NUM_HARTS == 1) begin
            w_state_nxt  = RUN;
            w_all_up_nxt = 1'b1;
            w_busy_nxt   = 1'b0;
          end else begin
            w_state_nxt  = RELEASE;
          end
        end else begin
          w_wcnt_nxt = r_wcnt + WK_W'(1);
        end
      end
      RELEASE: begin
        if (r_scnt == ST_W'(STAGGER_CYCLES - 1)) begin
          w_scnt_nxt                 = '0;
          w_idx_nxt                  = w_idx_inc;
          w_hart_rstn_nxt[w_idx_inc] = 1'b1;
          if (w_idx_inc == IDX_W'(NUM_HARTS - 1)) begin
            w_state_nxt  = RUN;
            w_all_up_nxt = 1'b1;
            w_busy_nxt   = 1'b0;
          end
        end else begin
          w_scnt_nxt = r_scnt + ST_W'(1);
        end
      end
      RUN: begin
        if (w_any) begin
          w_state_nxt            = HOLD;
          w_idx_nxt              = w_sel;
          w_hcnt_nxt             = '0;
          w_hart_rstn_nxt[w_sel] = 1'b0;
          w_armed_nxt[w_sel]     = 1'b0;
          w_all_up_nxt           = 1'b0;
          w_busy_nxt             = 1'b1;
        end
      end
      HOLD: begin
        if (r_hcnt == HD_W'(HOLD_CYCLES - 1)) begin
          w_state_nxt            = RUN;
          w_hart_rstn_nxt[r_idx] = 1'b1;
          w_ack_nxt[r_idx]       = 1'b1;
          w_all_up_nxt           = 1'b1;
          w_busy_nxt             = 1'b0;
        end else begin
          w_hcnt_nxt = r_hcnt + HD_W'(1);
        end
      end
      default: w_state_nxt = WAKE;
    endcase
  end

  assign hart_rst_no    = r_hart_rstn;
  assign soft_rst_ack_o = r_ack;
  assign all_up_o       = r_all_up;
  assign busy_o         = r_busy;

`ifdef LAGARTO_RST_SEQ_CNT_EN
  logic [NUM_HARTS-1:0][SOFT_CNT_W-1:0] r_cnt;

  // Counts on the same edge the ack is raised, so the new value appears with the pulse.
  always_ff @(posedge clk_i or posedge w_srst) begin
    if (w_srst) begin
      r_cnt <= '0;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++)
        if (w_ack_nxt[h] && (r_cnt[h] != '1)) r_cnt[h] <= r_cnt[h] + SOFT_CNT_W'(1);
    end
  end

  assign soft_rst_cnt_o = r_cnt;
`else
  assign soft_rst_cnt_o = '0;
`endif

endmodule

// File: tb/tb_lagarto_tile_rst_seq.sv
// Bench for lagarto_tile_rst_seq: timeline model of the reset sequencer,
// per-cycle comparison, directed scenarios and randomized requests/resets.
module tb_lagarto_tile_rst_seq;

  localparam int N    = 4;
  localparam int WAKE = 16;
  localparam int STG  = 3;
  localparam int HOLD = 8;
  localparam int SYNC = 2;
  localparam int UP0     = SYNC + WAKE;
  localparam int UP_LAST = UP0 + (N - 1) * STG;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  ack, rstn;
  logic          all_up, busy;
  logic [N*8-1:0] cnt;

  int checks = 0;
  int errors = 0;
  bit done = 0;

  lagarto_tile_rst_seq #(
    .NUM_HARTS(N), .WAKE_CYCLES(WAKE), .STAGGER_CYCLES(STG),
    .HOLD_CYCLES(HOLD), .SYNC_STAGES(SYNC)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .soft_rst_req_i (req),
    .soft_rst_ack_o (ack),
    .hart_rst_no    (rstn),
    .all_up_o       (all_up),
    .busy_o         (busy),
    .soft_rst_cnt_o (cnt)
  );

  always #5 clk = ~clk;

  // Timeline model: edge e counts rising edges since rst_i was last seen low.
  int           m_edge = -1;
  logic [N-1:0] m_rstn = '0, m_ack = '0, m_armed = '1;
  bit           m_allup = 0, m_busy = 1;
  int           m_hh = -1, m_hend = 0;
  int           m_cnt [N];
  int           e, h;

  initial for (int i = 0; i < N; i++) m_cnt[i] = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_edge = -1; m_rstn = '0; m_ack = '0; m_armed = '1;
      m_allup = 0; m_busy = 1; m_hh = -1;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      e = m_edge + 1;
      m_edge = e;
      m_ack = '0;
      m_armed = m_armed | ~req;
      if (e <= UP_LAST) begin
        for (int k = 0; k < N; k++) m_rstn[k] = (e >= UP0 + k * STG);
        if (e == UP_LAST) begin m_allup = 1; m_busy = 0; end
      end else if (m_hh >= 0) begin
        if (e == m_hend) begin
          m_rstn[m_hh] = 1'b1;
          m_ack[m_hh]  = 1'b1;
          if (m_cnt[m_hh] < 255) m_cnt[m_hh]++;
          m_hh = -1; m_allup = 1; m_busy = 0;
        end
      end else begin
        h = -1;
        for (int k = N - 1; k >= 0; k--) if (req[k] && m_armed[k]) h = k;
        if (h >= 0) begin
          m_rstn[h] = 1'b0; m_armed[h] = 1'b0;
          m_hh = h; m_hend = e + HOLD;
          m_allup = 0; m_busy = 1;
        end
      end
    end
  end

  function automatic logic [N*8-1:0] exp_cnt();
    logic [N*8-1:0] v;
    v = '0;
`ifdef LAGARTO_RST_SEQ_CNT_EN
    for (int i = 0; i < N; i++) v[i*8 +: 8] = 8'(m_cnt[i]);
`endif
    return v;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!done) begin
      checks++;
      if (rstn !== m_rstn || ack !== m_ack || all_up !== m_allup || busy !== m_busy || cnt !== exp_cnt()) begin
        errors++;
        $display("FAIL cycle edge=%0d: rstn=%b ack=%b up=%b busy=%b cnt=%h, expected rstn=%b ack=%b up=%b busy=%b cnt=%h",
                 m_edge, rstn, ack, all_up, busy, cnt, m_rstn, m_ack, m_allup, m_busy, exp_cnt());
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_edge(input int k);
    int guard;
    guard = 0;
    while (m_edge < k && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (m_edge < k) begin
      errors++;
      $display("FAIL wait_edge(%0d): timed out at edge %0d", k, m_edge);
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async rstn clear", rstn, 4'b0000);
    chk("async busy", busy, 1'b1);
    chk("async all_up", all_up, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  logic [31:0] c_exp;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset rstn", rstn, 4'b0000);
    chk("reset ack", ack, 4'b0000);
    chk("reset all_up", all_up, 1'b0);
    chk("reset busy", busy, 1'b1);
    chk("reset cnt", cnt, 32'h0);
    #1 rst = 1'b0;

    // 1. Power-up release timing
    wait_edge(17); chk("pu e17", rstn, 4'b0000);
    wait_edge(18); chk("pu e18", rstn, 4'b0001);
    wait_edge(20); chk("pu e20", rstn, 4'b0001);
    wait_edge(21); chk("pu e21", rstn, 4'b0011);
    wait_edge(24); chk("pu e24", rstn, 4'b0111);
    wait_edge(26); chk("pu e26 up", all_up, 1'b0);
    wait_edge(27); chk("pu e27", rstn, 4'b1111);
    chk("pu e27 up", all_up, 1'b1);
    chk("pu e27 busy", busy, 1'b0);

    // 2. Soft reset of hart 2
    wait_edge(40); req = 4'b0100;
    wait_edge(41); chk("sr2 e41", rstn, 4'b1011); chk("sr2 up", all_up, 1'b0);
    wait_edge(48); chk("sr2 e48", rstn, 4'b1011); chk("sr2 ack48", ack, 4'b0000);
    wait_edge(49); chk("sr2 e49", rstn, 4'b1111); chk("sr2 ack49", ack, 4'b0100);
    chk("sr2 up49", all_up, 1'b1);
`ifdef LAGARTO_RST_SEQ_CNT_EN
    c_exp = 32'h0001_0000;
`else
    c_exp = 32'h0;
`endif
    chk("sr2 cnt", cnt, {32'h0, c_exp});
    wait_edge(50); chk("sr2 ack50", ack, 4'b0000);
    req = 4'b0000;

    // 3. Simultaneous requests on harts 1 and 3
    wait_edge(60); req = 4'b1010;
    wait_edge(61); chk("sim e61", rstn, 4'b1101);
    wait_edge(69); chk("sim ack1", ack, 4'b0010); chk("sim e69", rstn, 4'b1111);
    wait_edge(70); chk("sim e70", rstn, 4'b0111);
    wait_edge(78); chk("sim ack3", ack, 4'b1000); chk("sim e78", rstn, 4'b1111);
    req = 4'b0000;

    // 4. Held request is not re-served; drop and raise re-arms
    wait_edge(90); req = 4'b0001;
    wait_edge(99); chk("hold ack0", ack, 4'b0001);
    wait_edge(129); chk("held e129", rstn, 4'b1111); chk("held busy", busy, 1'b0);
    wait_edge(130); req = 4'b0000;
    wait_edge(131); req = 4'b0001;
    wait_edge(132); chk("rearm e132", rstn, 4'b1110);
    wait_edge(140); chk("rearm ack", ack, 4'b0001);
    req = 4'b0000;

    // 5. Reset mid-RELEASE restarts the sequence; pending request served at RUN
    req = 4'b0100;
    pulse_rst();
    wait_edge(22); chk("rel e22", rstn, 4'b0011);
    pulse_rst();
    wait_edge(17); chk("rst e17", rstn, 4'b0000);
    wait_edge(18); chk("rst e18", rstn, 4'b0001);
    wait_edge(27); chk("rst e27", rstn, 4'b1111);
    wait_edge(28); chk("rst e28", rstn, 4'b1011);
    wait_edge(36); chk("rst ack", ack, 4'b0100);
    req = 4'b0000;

    // 6. Counter saturation on hart 0
    for (int n = 0; n < 260; n++) begin
      int g;
      @(negedge clk);
      req = 4'b0001;
      g = 0;
      do begin @(negedge clk); g++; end while (!ack[0] && g < 50);
      if (!ack[0]) begin
        errors++;
        $display("FAIL sat ack timeout: iteration %0d", n);
      end
      req = 4'b0000;
    end
`ifdef LAGARTO_RST_SEQ_CNT_EN
    chk("sat cnt0", cnt[7:0], 8'd255);
`else
    chk("sat cnt0", cnt[7:0], 8'd0);
`endif

    // Randomized requests with occasional reset pulses
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      if ($urandom_range(0, 399) == 0) begin
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
      end
    end

    @(negedge clk);
    done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
